// File: rtl/clock_set_ctrl_if.sv
// Configuration port between the time-setting controller and the real-time clock core.
// The controller drives load/addrs/data_in; the core reports its current time back.
interface clock_set_ctrl_if;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic [5:0] seconds_in;
  logic [5:0] minutes_in;
  logic [4:0] hours_in;

  modport master (
    output load, addrs, data_in,
    input  seconds_in, minutes_in, hours_in
  );

  modport slave (
    input  load, addrs, data_in,
    output seconds_in, minutes_in, hours_in
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller: edits hours, minutes, seconds, then commits
// all three to the clock core in a fixed 3-cycle load burst.
module clock_set_ctrl #(
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    btn_mode,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  clock_set_ctrl_if.master        core,
  output logic                    edit_active,
  output logic [1:0]              edit_field,
  output logic [5:0]              edit_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_H,
    S_EDIT_M,
    S_EDIT_S,
    S_COMMIT_H,
    S_COMMIT_M,
    S_COMMIT_S
  } state_t;

  localparam logic [5:0] LP_TIMEOUT = 6'(TIMEOUT_TICKS);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_mode_hist, r_inc_hist, r_dec_hist;
  logic [4:0] r_h;
  logic [5:0] r_m, r_s;
  logic [5:0] r_cnt;

  logic       w_mode_edge, w_inc_edge, w_dec_edge, w_any_edge;
  logic       w_editing, w_timeout;
  logic       w_adj_up, w_adj_dn;
  logic [5:0] w_field_max, w_field_up, w_field_dn, w_field_new;

  assign w_mode_edge = btn_mode & ~r_mode_hist;
  assign w_inc_edge  = btn_inc  & ~r_inc_hist;
  assign w_dec_edge  = btn_dec  & ~r_dec_hist;
  assign w_any_edge  = w_mode_edge | w_inc_edge | w_dec_edge;

  assign w_editing = (r_state == S_EDIT_H) || (r_state == S_EDIT_M) || (r_state == S_EDIT_S);
  // Abandon on the tick that brings the count to the limit; any edge this cycle restarts it instead.
  assign w_timeout = w_editing && !w_any_edge && tick && ((r_cnt + 6'd1) == LP_TIMEOUT);

  // Mode outranks inc/dec; inc together with dec cancels out.
  assign w_adj_up = w_inc_edge & ~w_dec_edge & ~w_mode_edge;
  assign w_adj_dn = w_dec_edge & ~w_inc_edge & ~w_mode_edge;

  assign w_field_max = (edit_field == 2'b10) ? 6'd23 : 6'd59;
  assign w_field_up  = (edit_value == w_field_max) ? 6'd0 : edit_value + 6'd1;
  assign w_field_dn  = (edit_value == 6'd0) ? w_field_max : edit_value - 6'd1;
  assign w_field_new = w_adj_up ? w_field_up : w_field_dn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_mode_edge) w_state_next = S_EDIT_H;
      S_EDIT_H:   if (w_mode_edge) w_state_next = S_EDIT_M;
                  else if (w_timeout) w_state_next = S_IDLE;
      S_EDIT_M:   if (w_mode_edge) w_state_next = S_EDIT_S;
                  else if (w_timeout) w_state_next = S_IDLE;
      S_EDIT_S:   if (w_mode_edge) w_state_next = S_COMMIT_H;
                  else if (w_timeout) w_state_next = S_IDLE;
      S_COMMIT_H: w_state_next = S_COMMIT_M;
      S_COMMIT_M: w_state_next = S_COMMIT_S;
      S_COMMIT_S: w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    core.load    = 1'b0;
    core.addrs   = 2'b00;
    core.data_in = 6'd0;
    edit_active  = 1'b0;
    edit_field   = 2'b00;
    edit_value   = 6'd0;
    case (r_state)
      S_EDIT_H: begin
        edit_active = 1'b1;
        edit_field  = 2'b10;
        edit_value  = {1'b0, r_h};
      end
      S_EDIT_M: begin
        edit_active = 1'b1;
        edit_field  = 2'b01;
        edit_value  = r_m;
      end
      S_EDIT_S: begin
        edit_active = 1'b1;
        edit_field  = 2'b00;
        edit_value  = r_s;
      end
      S_COMMIT_H: begin
        core.load    = 1'b1;
        core.addrs   = 2'b10;
        core.data_in = {1'b0, r_h};
      end
      S_COMMIT_M: begin
        core.load    = 1'b1;
        core.addrs   = 2'b01;
        core.data_in = r_m;
      end
      S_COMMIT_S: begin
        core.load    = 1'b1;
        core.addrs   = 2'b00;
        core.data_in = r_s;
      end
      default: ;
    endcase
  end

  // Edit registers, inactivity counter and button history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_hist <= 1'b0;
      r_inc_hist  <= 1'b0;
      r_dec_hist  <= 1'b0;
      r_h         <= 5'd0;
      r_m         <= 6'd0;
      r_s         <= 6'd0;
      r_cnt       <= 6'd0;
    end else begin
      r_mode_hist <= btn_mode;
      r_inc_hist  <= btn_inc;
      r_dec_hist  <= btn_dec;
      if (r_state == S_IDLE && w_mode_edge) begin
        r_h   <= core.hours_in;
        r_m   <= core.minutes_in;
        r_s   <= core.seconds_in;
        r_cnt <= 6'd0;
      end else if (w_editing) begin
        if (w_any_edge) begin
          r_cnt <= 6'd0;
        end else if (tick) begin
          r_cnt <= r_cnt + 6'd1;
        end
        if (w_adj_up || w_adj_dn) begin
          case (edit_field)
            2'b10:   r_h <= w_field_new[4:0];
            2'b01:   r_m <= w_field_new;
            default: r_s <= w_field_new;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a small clock-core model on the slave side
// that accepts loads (ignored while reset is high).
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic reset, tick, btn_mode, btn_inc, btn_dec;
  logic edit_active;
  logic [1:0] edit_field;
  logic [5:0] edit_value;

  logic [4:0] core_h;
  logic [5:0] core_m, core_s;
  int n_checks = 0;
  int n_errors = 0;
  int n_loads = 0;
  int loads_before;

  clock_set_ctrl_if ifc ();

  clock_set_ctrl #(.TIMEOUT_TICKS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .core        (ifc.master),
    .edit_active (edit_active),
    .edit_field  (edit_field),
    .edit_value  (edit_value)
  );

  always #5 clk = ~clk;

  assign ifc.hours_in   = core_h;
  assign ifc.minutes_in = core_m;
  assign ifc.seconds_in = core_s;

  always @(posedge clk) begin
    if (!reset && ifc.load) begin
      case (ifc.addrs)
        2'b10:   core_h <= ifc.data_in[4:0];
        2'b01:   core_m <= ifc.data_in;
        default: core_s <= ifc.data_in;
      endcase
    end
  end

  always @(negedge clk) if (ifc.load) n_loads++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0: mode, 1: inc, 2: dec, 3: inc+dec, 4: mode+inc
  task automatic press(input int which);
    btn_mode = (which == 0 || which == 4);
    btn_inc  = (which == 1 || which == 3 || which == 4);
    btn_dec  = (which == 2 || which == 3);
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic set_core(input int h, input int m, input int s);
    @(negedge clk);
    core_h = 5'(h);
    core_m = 6'(m);
    core_s = 6'(s);
    step();
  endtask

  task automatic check_core(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, 32'(core_h), 32'(h));
    check({tag, "_m"}, 32'(core_m), 32'(m));
    check({tag, "_s"}, 32'(core_s), 32'(s));
  endtask

  // Final mode press in EDIT_S, checking the burst cycle by cycle.
  task automatic commit_burst(input string tag, input int h, input int m, input int s);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check({tag, "_ch_load"}, 32'(ifc.load), 1);
    check({tag, "_ch_addr"}, 32'(ifc.addrs), 2);
    check({tag, "_ch_data"}, 32'(ifc.data_in), 32'(h));
    step();
    check({tag, "_cm_load"}, 32'(ifc.load), 1);
    check({tag, "_cm_addr"}, 32'(ifc.addrs), 1);
    check({tag, "_cm_data"}, 32'(ifc.data_in), 32'(m));
    step();
    check({tag, "_cs_load"}, 32'(ifc.load), 1);
    check({tag, "_cs_addr"}, 32'(ifc.addrs), 0);
    check({tag, "_cs_data"}, 32'(ifc.data_in), 32'(s));
    step();
    check({tag, "_end_load"}, 32'(ifc.load), 0);
    check({tag, "_end_active"}, 32'(edit_active), 0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    core_h = 5'd12; core_m = 6'd34; core_s = 6'd56;
    repeat (3) step();
    reset = 1'b0;

    // Reset state and idle behaviour
    check("rst_field", 32'(edit_field), 0);
    check("rst_value", 32'(edit_value), 0);
    for (int i = 0; i < 5; i++) begin
      check("idle_load", 32'(ifc.load), 0);
      check("idle_addrs", 32'(ifc.addrs), 0);
      check("idle_data", 32'(ifc.data_in), 0);
      check("idle_active", 32'(edit_active), 0);
      step();
    end
    press(1);
    press(2);
    check("idle_incdec_active", 32'(edit_active), 0);
    check("idle_incdec_loads", 32'(n_loads), 0);

    // Basic edit: 12:34:56 -> 14:33:56
    press(0);
    check("basic_active", 32'(edit_active), 1);
    check("basic_field_h", 32'(edit_field), 2);
    check("basic_h_cap", 32'(edit_value), 12);
    press(1);
    press(1);
    check("basic_h_inc2", 32'(edit_value), 14);
    press(0);
    check("basic_field_m", 32'(edit_field), 1);
    press(2);
    check("basic_m_dec", 32'(edit_value), 33);
    press(0);
    check("basic_field_s", 32'(edit_field), 0);
    check("basic_s_cap", 32'(edit_value), 56);
    loads_before = n_loads;
    commit_burst("basic", 14, 33, 56);
    check("basic_nloads", 32'(n_loads - loads_before), 3);
    check_core("basic_core", 14, 33, 56);

    // Wrap-around: 23:00:59 -> 00:59:00
    set_core(23, 0, 59);
    press(0);
    press(1);
    check("wrap_h", 32'(edit_value), 0);
    press(0);
    press(2);
    check("wrap_m", 32'(edit_value), 59);
    press(0);
    press(1);
    check("wrap_s", 32'(edit_value), 0);
    commit_burst("wrap", 0, 59, 0);
    check_core("wrap_core", 0, 59, 0);

    // Simultaneous edges and held button: 05:10:20 -> 05:11:20
    set_core(5, 10, 20);
    press(0);
    press(4);
    check("sim_mode_inc_field", 32'(edit_field), 1);
    do_tick();
    do_tick();
    press(3);
    check("sim_incdec_m", 32'(edit_value), 10);
    do_tick();
    do_tick();
    check("sim_incdec_no_timeout", 32'(edit_active), 1);
    btn_inc = 1'b1;
    repeat (20) step();
    btn_inc = 1'b0;
    step();
    check("held_inc_m", 32'(edit_value), 11);
    press(0);
    commit_burst("sim", 5, 11, 20);
    check_core("sim_core", 5, 11, 20);

    // Timeout after 3 ticks with no edges
    loads_before = n_loads;
    press(0);
    do_tick();
    do_tick();
    check("to_after2_active", 32'(edit_active), 1);
    do_tick();
    check("to_after3_active", 32'(edit_active), 0);
    check("to_after3_field", 32'(edit_field), 0);
    check("to_no_load", 32'(n_loads - loads_before), 0);
    press(0);
    do_tick();
    do_tick();
    press(1);
    do_tick();
    do_tick();
    check("to_restart_active", 32'(edit_active), 1);
    check("to_restart_h", 32'(edit_value), 6);
    do_tick();
    check("to_restart_expire", 32'(edit_active), 0);
    check("to_restart_no_load", 32'(n_loads - loads_before), 0);
    check_core("to_core", 5, 11, 20);

    // Reset during COMMIT_M: only hours reach the core
    set_core(12, 34, 56);
    press(0);
    press(1);
    press(0);
    press(1);
    press(0);
    press(1);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("rcm_ch_load", 32'(ifc.load), 1);
    step();
    check("rcm_cm_addr", 32'(ifc.addrs), 1);
    reset = 1'b1;
    step();
    check("rcm_load", 32'(ifc.load), 0);
    check("rcm_addrs", 32'(ifc.addrs), 0);
    check("rcm_active", 32'(edit_active), 0);
    reset = 1'b0;
    step();
    check("rcm_after_load", 32'(ifc.load), 0);
    check("rcm_after_value", 32'(edit_value), 0);
    check_core("rcm_core", 13, 34, 56);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Button-driven time-setting controller for the real-time clock core. It sequences the core's shared load/addrs/data_in configuration port.
- The user edits hours, then minutes, then seconds. On exit, the controller commits all three fields to the core in a fixed 3-cycle burst.
- Sits between the debounced front-panel buttons and the clock core. It also exports edit status for the display.

Parameters:
- TIMEOUT_TICKS, 30, number of tick strobes with no button edge before an edit session is abandoned without loading (range 1..63).

Ports:
- clk  input  1  system clock (single clock domain).
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle 1 Hz strobe from the clock core's time base.
- btn_mode  input  1  debounced, synchronous level; rising edge advances the edit state.
- btn_inc  input  1  debounced, synchronous level; rising edge increments the field being edited.
- btn_dec  input  1  debounced, synchronous level; rising edge decrements the field being edited.
- seconds_in  input  6  current seconds value from the clock core.
- minutes_in  input  6  current minutes value from the clock core.
- hours_in  input  5  current hours value from the clock core.
- load  output  1  load strobe to the clock core.
- addrs  output  2  field select to the clock core: 00 = seconds, 01 = minutes, 10 = hours; 11 is never driven.
- data_in  output  6  value to load; hours are zero-extended.
- edit_active  output  1  high in any EDIT state.
- edit_field  output  2  field under edit (same encoding as addrs); 00 when not editing.
- edit_value  output  6  working value of the field under edit; 0 when not editing.

Behaviour:
- Reset values: state = IDLE; load = 0; addrs = 00; data_in = 0; edit_active = 0; edit_field = 00; edit_value = 0; edit registers h/m/s = 0; timeout counter = 0; button history registers = 0.
- Edge detection: an edge is registered when a button is 1 at a clk edge and its history register holds 0. The history register updates every cycle. Holding a button produces exactly one edge.
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT_H, COMMIT_M, COMMIT_S. All outputs are a Moore decode of registered state and edit registers.
- IDLE:
  - A mode edge captures hours_in, minutes_in and seconds_in into the edit registers and moves to EDIT_H.
  - inc/dec edges are ignored.
- EDIT_H / EDIT_M / EDIT_S:
  - A mode edge advances EDIT_H -> EDIT_M -> EDIT_S -> COMMIT_H.
  - An inc edge adds 1 to the active field; a dec edge subtracts 1.
  - Hours wrap 23 -> 0 and 0 -> 23. Minutes and seconds wrap 59 -> 0 and 0 -> 59.
- Simultaneous events in the same cycle:
  - mode together with inc or dec: mode wins and the field is unchanged.
  - inc together with dec: no change, but the timeout counter still clears.
- Timeout:
  - The counter clears on entry to EDIT_H and on any button edge while in an EDIT state.
  - It increments on each tick while in an EDIT state.
  - When it reaches TIMEOUT_TICKS, the controller returns to IDLE with no load; the edit registers are retained but unused.
- COMMIT states: each lasts exactly one cycle, with load = 1.
  - COMMIT_H drives addrs = 10, data_in = {1'b0, h}.
  - COMMIT_M drives addrs = 01, data_in = m.
  - COMMIT_S drives addrs = 00, data_in = s.
  - Sequence is COMMIT_H -> COMMIT_M -> COMMIT_S -> IDLE.
  - Button edges during COMMIT are ignored (history registers still update).
  - A burst always loads all three fields, so load is high for exactly 3 consecutive cycles.
- Outside COMMIT states: load = 0, addrs = 00, data_in = 0.
- Core time during editing: the clock core keeps counting while editing. The captured values are not refreshed; the commit overwrites the core's time.
- Latency: from the cycle the mode edge is detected in EDIT_S, load is first asserted 1 cycle later (on entry to COMMIT_H).
- Reset mid-operation, including mid-COMMIT: the controller returns immediately to the reset values. There is no partial-burst continuation; any fields already loaded remain in the core.
- Edit-register legality: edit registers never hold illegal values (h <= 23, m,s <= 59) because captured inputs are always legal from the core.

Test Plan:
- Reset, then 5 idle cycles -> load = 0, addrs = 00, data_in = 0, edit_active = 0 throughout; inc/dec edges in IDLE have no effect.
- Core at 12:34:56; mode, 2x inc, mode, dec, mode, mode -> load high for 3 cycles with (addrs, data_in) = (10, 14), (01, 33), (00, 56), then IDLE.
- Wrap-around: hours 23 with inc -> edit_value 0; minutes 0 with dec -> 59; seconds 59 with inc -> 0; the committed values match.
- Simultaneous edges: mode + inc in EDIT_H -> state EDIT_M and h unchanged; inc + dec in EDIT_M -> m unchanged and no timeout; a held btn_inc for 20 cycles -> exactly +1.
- Timeout with TIMEOUT_TICKS = 3: enter EDIT_H, then 3 ticks with no edges -> IDLE, no load asserted. A second run with an inc edge after 2 ticks -> still editing after 4 total ticks.
- Reset asserted during COMMIT_M -> the next cycle has load = 0 and state IDLE. The core holds the new hours but its original minutes/seconds (it was loaded only at COMMIT_H).
